// File: rtl/matrix_scan_ctrl.sv
// ----------------------------------------------------------------------------
// matrix_scan_ctrl : 5x7 LED matrix line scanner with double-buffered frames
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module matrix_scan_ctrl #(
  parameter int DIV   = 1000,
  parameter int BLANK = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [2:0] wr_line,
  input  logic [6:0] wr_data,
  input  logic       commit,
  output logic       commit_pend,
  output logic [2:0] sel,
  output logic [4:0] line_en,
  output logic [6:0] col_n,
  output logic       frame_start
);

  localparam int             PW          = $clog2(DIV);
  localparam logic [PW-1:0]  C_PRESC_MAX = PW'(DIV - 1);
  localparam logic [PW-1:0]  C_BLANK     = PW'(BLANK);
  localparam logic [2:0]     C_SEL_LAST  = 3'd4;

  logic [PW-1:0]   r_presc;
  logic [2:0]      r_sel;
  logic [4:0][6:0] r_front;
  logic [4:0][6:0] r_back;
  logic            r_commit_pend;
  logic [4:0]      r_line_en;
  logic [6:0]      r_col_n;
  logic            r_frame_start;

  logic            w_slot_end;
  logic            w_wrap;
  logic            w_swap;
  logic            w_wr_ok;
  logic            w_drive;
  logic            w_pend_nxt;
  logic [PW-1:0]   w_presc_nxt;
  logic [2:0]      w_sel_nxt;
  logic [4:0][6:0] w_front_nxt;

  always_comb begin
    w_slot_end  = (r_presc == C_PRESC_MAX);
    w_wrap      = w_slot_end && (r_sel == C_SEL_LAST);
    w_swap      = w_wrap && r_commit_pend;
    w_wr_ok     = wr_en && (wr_line <= C_SEL_LAST);
    w_presc_nxt = w_slot_end ? '0 : r_presc + 1'b1;
    w_sel_nxt   = r_sel;
    if (w_slot_end) begin
      w_sel_nxt = w_wrap ? 3'd0 : r_sel + 3'd1;
    end
    // Front samples back before this edge's write lands, so a write on the
    // swap edge only reaches the display at the following boundary.
    w_front_nxt = w_swap ? r_back : r_front;
    w_pend_nxt  = commit || (r_commit_pend && !w_swap);
    w_drive     = (w_presc_nxt >= C_BLANK);
  end

  // Outputs are computed from next-state values so they line up with the
  // prescaler/sel registers in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc       <= '0;
      r_sel         <= '0;
      r_front       <= '0;
      r_back        <= '0;
      r_commit_pend <= 1'b0;
      r_line_en     <= '0;
      r_col_n       <= 7'h7F;
      r_frame_start <= 1'b0;
    end else begin
      r_presc       <= w_presc_nxt;
      r_sel         <= w_sel_nxt;
      r_front       <= w_front_nxt;
      r_commit_pend <= w_pend_nxt;
      r_frame_start <= w_wrap;
      if (w_wr_ok) begin
        r_back[wr_line] <= wr_data;
      end
      if (w_drive) begin
        r_line_en <= 5'b00001 << w_sel_nxt;
        r_col_n   <= ~w_front_nxt[w_sel_nxt];
      end else begin
        r_line_en <= '0;
        r_col_n   <= 7'h7F;
      end
    end
  end

  assign commit_pend = r_commit_pend;
  assign sel         = r_sel;
  assign line_en     = r_line_en;
  assign col_n       = r_col_n;
  assign frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_matrix_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_matrix_scan_ctrl : directed self-checking bench for matrix_scan_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_matrix_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 5 * DIV;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [2:0] wr_line;
  logic [6:0] wr_data;
  logic       commit;
  logic       commit_pend;
  logic [2:0] sel;
  logic [4:0] line_en;
  logic [6:0] col_n;
  logic       frame_start;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  matrix_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_line     (wr_line),
    .wr_data     (wr_data),
    .commit      (commit),
    .commit_pend (commit_pend),
    .sel         (sel),
    .line_en     (line_en),
    .col_n       (col_n),
    .frame_start (frame_start)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // cyc counts rising edges since the last reset release.
  function automatic logic [2:0] exp_sel(int c);
    return 3'((c / DIV) % 5);
  endfunction

  function automatic logic [4:0] exp_len(int c);
    return ((c % DIV) >= BLANK) ? (5'b00001 << exp_sel(c)) : 5'd0;
  endfunction

  function automatic logic [6:0] exp_col(int c, logic [4:0][6:0] lines);
    return ((c % DIV) >= BLANK) ? ~lines[exp_sel(c)] : 7'h7F;
  endfunction

  function automatic logic exp_fs(int c);
    return (c > 0) && ((c % FRAME) == 0);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; wr_en = 1'b0; wr_line = '0; wr_data = '0; commit = 1'b0;
    repeat (3) tick();
    n_checks++; if (sel !== 3'd0)         begin n_errors++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    n_checks++; if (line_en !== 5'd0)     begin n_errors++; $display("FAIL reset_line_en got=%b exp=00000", line_en); end
    n_checks++; if (col_n !== 7'h7F)      begin n_errors++; $display("FAIL reset_col_n got=%h exp=7f", col_n); end
    n_checks++; if (frame_start !== 1'b0) begin n_errors++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end
    n_checks++; if (commit_pend !== 1'b0) begin n_errors++; $display("FAIL reset_commit_pend got=%b exp=0", commit_pend); end
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_scan_idle();
    logic [4:0][6:0] lines = '0;
    while (cyc < 200) begin
      n_checks++;
      if ({sel, line_en, col_n, frame_start, commit_pend} !==
          {exp_sel(cyc), exp_len(cyc), exp_col(cyc, lines), exp_fs(cyc), 1'b0}) begin
        n_errors++;
        $display("FAIL scan_idle cyc=%0d got sel=%0d len=%b col=%h fs=%b pend=%b exp sel=%0d len=%b col=%h fs=%b",
                 cyc, sel, line_en, col_n, frame_start, commit_pend,
                 exp_sel(cyc), exp_len(cyc), exp_col(cyc, lines), exp_fs(cyc));
      end
      tick();
    end
  endtask

  task automatic test_commit();
    logic [4:0][6:0] lines = '0;
    wr_en = 1'b1; wr_line = 3'd2; wr_data = 7'h55;
    tick();
    wr_en = 1'b0; commit = 1'b1;
    tick();
    commit = 1'b0;
    while (cyc < 280) begin
      if (cyc == 240) lines[2] = 7'h55;
      n_checks++;
      if ({sel, line_en, col_n, frame_start, commit_pend} !==
          {exp_sel(cyc), exp_len(cyc), exp_col(cyc, lines), exp_fs(cyc), (cyc < 240)}) begin
        n_errors++;
        $display("FAIL commit cyc=%0d got sel=%0d len=%b col=%h fs=%b pend=%b exp len=%b col=%h pend=%b",
                 cyc, sel, line_en, col_n, frame_start, commit_pend,
                 exp_len(cyc), exp_col(cyc, lines), (cyc < 240));
      end
      tick();
    end
  endtask

  task automatic test_commit_on_wrap();
    logic [4:0][6:0] lines = '0;
    logic            pend;
    lines[2] = 7'h55;
    wr_line = 3'd4; wr_data = 7'h7F;
    while (cyc < 400) begin
      if (cyc == 360) lines[4] = 7'h7F;
      pend = (cyc >= 291) && (cyc < 360);
      n_checks++;
      if ({sel, line_en, col_n, frame_start, commit_pend} !==
          {exp_sel(cyc), exp_len(cyc), exp_col(cyc, lines), exp_fs(cyc), pend}) begin
        n_errors++;
        $display("FAIL commit_on_wrap cyc=%0d got sel=%0d len=%b col=%h fs=%b pend=%b exp len=%b col=%h pend=%b",
                 cyc, sel, line_en, col_n, frame_start, commit_pend,
                 exp_len(cyc), exp_col(cyc, lines), pend);
      end
      commit = (cyc == 290) || (cyc == 295) || (cyc == 319);
      wr_en  = (cyc == 319);
      tick();
    end
    commit = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [4:0][6:0] lines = '0;
    lines[2] = 7'h55; lines[4] = 7'h7F;
    while (cyc < 428) begin
      n_checks++;
      if ({sel, line_en, col_n, commit_pend} !==
          {exp_sel(cyc), exp_len(cyc), exp_col(cyc, lines), (cyc >= 401)}) begin
        n_errors++;
        $display("FAIL pre_reset cyc=%0d got sel=%0d len=%b col=%h pend=%b exp sel=%0d len=%b pend=%b",
                 cyc, sel, line_en, col_n, commit_pend, exp_sel(cyc), exp_len(cyc), (cyc >= 401));
      end
      commit = (cyc == 400);
      tick();
    end
    commit = 1'b0;
    reset_n = 1'b0;
    #1;
    n_checks++; if (line_en !== 5'd0)     begin n_errors++; $display("FAIL midreset_line_en got=%b exp=00000", line_en); end
    n_checks++; if (col_n !== 7'h7F)      begin n_errors++; $display("FAIL midreset_col_n got=%h exp=7f", col_n); end
    n_checks++; if (commit_pend !== 1'b0) begin n_errors++; $display("FAIL midreset_commit_pend got=%b exp=0", commit_pend); end
    n_checks++; if (sel !== 3'd0)         begin n_errors++; $display("FAIL midreset_sel got=%0d exp=0", sel); end
    repeat (2) tick();
    reset_n = 1'b1;
    cyc = 0;
    lines = '0;
    while (cyc < 40) begin
      n_checks++;
      if ({sel, line_en, col_n, frame_start, commit_pend} !==
          {exp_sel(cyc), exp_len(cyc), exp_col(cyc, lines), exp_fs(cyc), 1'b0}) begin
        n_errors++;
        $display("FAIL post_reset cyc=%0d got sel=%0d len=%b col=%h fs=%b pend=%b",
                 cyc, sel, line_en, col_n, frame_start, commit_pend);
      end
      tick();
    end
  endtask

  task automatic test_bad_line();
    logic [4:0][6:0] lines = '0;
    wr_line = 3'd6; wr_data = 7'h01;
    while (cyc < 120) begin
      n_checks++;
      if ({sel, line_en, col_n, frame_start, commit_pend} !==
          {exp_sel(cyc), exp_len(cyc), exp_col(cyc, lines), exp_fs(cyc), (cyc >= 42 && cyc < 80)}) begin
        n_errors++;
        $display("FAIL bad_line cyc=%0d got sel=%0d len=%b col=%h fs=%b pend=%b exp col=%h pend=%b",
                 cyc, sel, line_en, col_n, frame_start, commit_pend,
                 exp_col(cyc, lines), (cyc >= 42 && cyc < 80));
      end
      wr_en  = (cyc == 40);
      commit = (cyc == 41);
      tick();
    end
    wr_en = 1'b0; commit = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_idle();
    test_commit();
    test_commit_on_wrap();
    test_reset_mid();
    test_bad_line();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/matrix_scan_ctrl.md
MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 Parameter DIV, default 1000: clk cycles per column slot; legal range 4..65535.
REQ-002 Parameter BLANK, default 2: blanked clk cycles at the start of each slot; legal range 1..DIV-2.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 wr_en  input  1  write strobe into the back buffer.
REQ-006 wr_line  input  3  target line index for a write, 0..4.
REQ-007 wr_data  input  7  pixel bits C1..C7 for that line; 1 = lit.
REQ-008 commit  input  1  request to swap the back buffer to the front at the next frame boundary.
REQ-009 commit_pend  output  1  high while an accepted commit awaits its swap.
REQ-010 sel  output  3  line select count driven to the column multiplexers, 0..4.
REQ-011 line_en  output  5  one-hot active-high line drive; bit i corresponds to sel = i.
REQ-012 col_n  output  7  column drive, active low; 0 = pixel lit.
REQ-013 frame_start  output  1  one-cycle pulse when sel wraps from 4 to 0.

Function
REQ-014 The block SHALL hold two 5x7 buffers (front and back), 70 bits total.
REQ-015 The block SHALL display only the front buffer; all writes go to the back buffer.
REQ-016 A write with wr_en=1 and wr_line<=4 SHALL update back[wr_line] on that edge, regardless of scan state.
REQ-017 A write with wr_line 5..7 SHALL be ignored; no state change.
REQ-018 A prescaler SHALL count 0..DIV-1 and wrap; each wrap ends a slot.
- At a slot end, sel SHALL advance 0->1->2->3->4->0.
REQ-019 Blanking and drive within a slot:
- Prescaler < BLANK: line_en SHALL be 0 and col_n SHALL be 7'h7F.
- Otherwise: line_en SHALL be one-hot on sel, and col_n SHALL be ~front[sel].
- Outputs SHALL be registered, with no combinational path from inputs.
REQ-020 frame_start SHALL pulse high for exactly the first cycle of the slot where sel becomes 0.
REQ-021 commit=1 SHALL set commit_pend on the next edge; repeated commits while pending SHALL be absorbed.
REQ-022 Frame-boundary swap:
- On the edge where sel wraps 4->0 with commit_pend=1, front SHALL take the full back contents and commit_pend SHALL clear.
- Back SHALL be retained unchanged.
REQ-023 Simultaneous events on the swap edge:
- A write SHALL land in back after the copy; front SHALL receive the pre-write back value.
- A new commit on that edge SHALL set commit_pend again for the next frame.
REQ-024 A swap SHALL never occur mid-frame; a commit arriving on the last cycle before the wrap SHALL be taken at the following boundary, not the current one.
REQ-025 Scan period SHALL be exactly 5*DIV cycles per frame; frame_start pulses SHALL be spaced 5*DIV cycles apart.

Reset
REQ-026 While reset_n=0, the following SHALL hold asynchronously:
- prescaler = 0, sel = 0
- both buffers all-zero, commit_pend = 0
- line_en = 0, col_n = 7'h7F, frame_start = 0
REQ-027 After reset_n rises, the first slot SHALL begin with sel=0 and BLANK blanked cycles; no frame_start pulse SHALL be issued for this first frame.
REQ-028 A reset asserted mid-slot or mid-commit SHALL discard the pending commit and buffer contents; outputs SHALL go dark immediately.

Verification (DIV=8, BLANK=2)
REQ-029 Reset release, no writes -> col_n stays 7'h7F for 200 cycles; line_en pattern cycles 01,02,04,08,10 with 6-cycle active windows; sel sequence 0..4 repeats.
REQ-030 Write line 2 = 7'h55, commit at cycle 3 -> commit_pend high until the next 4->0 wrap; thereafter, in sel=2 active cycles, col_n=7'h2A and line_en=5'b00100.
REQ-031 Write line 4 = 7'h7F and commit on the same edge as the 4->0 wrap (old back line 4 = 0) -> next frame line 4 shows col_n=7'h7F (dark); commit_pend is set again; the following frame shows col_n=7'h00.
REQ-032 wr_line=6 with wr_data=7'h01, then commit -> no column is lit in any slot after the swap.
REQ-033 reset_n pulsed low in sel=3 while commit_pend=1 -> outputs dark within the same cycle; after release commit_pend=0, sel=0, and no lit pixels appear.
